cacheline_adaptor: RTL and testbench

- Responder on the cache's physical-memory side. It accepts one 256-bit line read or write per request, held until acknowledged.
- Converts each request into a 4-beat, 64-bit burst transaction on the main-memory bus.
- Sits between the cache (pmem_* signals) and the burst memory model / arbiter.
- Returns a single-cycle pmem_resp when the whole line transfer is complete.

---
 rtl/cacheline_adaptor_pkg.sv | 21 ++
 rtl/cacheline_adaptor.sv | 116 +++++++++++
 tb/tb_cacheline_adaptor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and helpers for the cache-line to burst-memory adaptor.
package cacheline_adaptor_types;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_BURST,
    ST_RD_DONE,
    ST_WR_BURST,
    ST_WR_DONE
  } adaptor_state_t;

  // Select beat k (beat 0 = least-significant 64 bits) out of a full line.
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [BEATS*BEAT_W-1:0] line,
                                                   input logic [1:0]              k);
    return line[k*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one held 256-bit line read/write from the cache into a 4-beat,
// 64-bit burst on the memory bus and pulses pmem_resp once the line is done.
module cacheline_adaptor
  import cacheline_adaptor_types::*;
#(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_wdata,
  output logic [s_line-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [31:0]       bmem_address,
  output logic [s_burst-1:0] bmem_wdata,
  input  logic [s_burst-1:0] bmem_rdata,
  input  logic              bmem_resp
);

  localparam int num_beats = s_line / s_burst;

  adaptor_state_t      state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [31:0]         addr_q, addr_d;
  logic [s_line-1:0]   line_buf_q;
  logic [num_beats-1:0] cap_en;
  logic [31:0]         aligned_addr;

  // Offset bits are dropped on purpose: the burst always starts on a line boundary.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^pmem_address[s_offset-1:0];
  assign aligned_addr    = {pmem_address[31:s_offset], {s_offset{1'b0}}};

  // State, beat counter and latched burst address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: write wins in IDLE; the 4th beat closes the burst.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (pmem_write) begin
          addr_d  = aligned_addr;
          state_d = ST_WR_BURST;
        end else if (pmem_read) begin
          addr_d  = aligned_addr;
          state_d = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        if (bmem_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = ST_RD_DONE;
        end
      end
      ST_WR_BURST: begin
        if (bmem_resp) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = ST_WR_DONE;
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // One capture strobe per beat slot of the line buffer.
  for (genvar gi = 0; gi < num_beats; gi++) begin : g_cap
    assign cap_en[gi] = (state_q == ST_RD_BURST) && bmem_resp && (beat_q == 2'(gi));
  end

  // Line buffer: each read beat lands in its slot; contents persist between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_buf_q <= '0;
    end else begin
      for (int i = 0; i < num_beats; i++) begin
        if (cap_en[i]) line_buf_q[i*s_burst +: s_burst] <= bmem_rdata;
      end
    end
  end

  // Bus-side outputs decode straight from state so a reset drops them at once.
  assign bmem_read    = (state_q == ST_RD_BURST);
  assign bmem_write   = (state_q == ST_WR_BURST);
  assign bmem_address = addr_q;
  assign bmem_wdata   = (state_q == ST_WR_BURST) ? beat_slice(pmem_wdata, beat_q) : '0;
  assign pmem_resp    = (state_q == ST_RD_DONE) || (state_q == ST_WR_DONE);
  assign pmem_rdata   = line_buf_q;

  // Both requests high at once is a cache protocol violation.
  assert property (@(posedge clk) disable iff (rst)
                   (state_q == ST_IDLE) |-> !(pmem_read && pmem_write))
    else $error("cacheline_adaptor: pmem_read and pmem_write both asserted");

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench: line-level reference model (expected line, aligned
// address, expected beat order) against the adaptor.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic         bmem_read, bmem_write;
  logic [31:0]  bmem_address;
  logic [63:0]  bmem_wdata, bmem_rdata;
  logic         bmem_resp;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_line;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_address(bmem_address), .bmem_wdata(bmem_wdata),
    .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Random beat-strobe pattern (LSB first) containing exactly four ones.
  function automatic logic [15:0] rand_pat();
    logic [15:0] p = '0;
    int ones = 0;
    for (int i = 0; i < 16 && ones < 4; i++) begin
      if ((16 - i) <= (4 - ones) || $urandom_range(0, 2) != 0) begin
        p[i] = 1'b1;
        ones++;
      end
    end
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; pmem_read = 0; pmem_write = 0; pmem_address = 0; pmem_wdata = 0;
    bmem_rdata = 0; bmem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({pmem_resp, bmem_read, bmem_write} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {pmem_resp, bmem_read, bmem_write}); end
    checks++; if (pmem_rdata !== 256'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", pmem_rdata); end
    checks++; if (bmem_address !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bmem_address); end
    checks++; if (bmem_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", bmem_wdata); end
    rst = 1'b0;
    last_line = '0;
    $display("reset: outputs checked");
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [255:0] line, input logic [15:0] pat);
    int beats = 0;
    int cyc = 1;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    pmem_read = 1'b1; pmem_address = addr;
    @(posedge clk); #1;
    checks++; if (bmem_read !== 1'b1 || bmem_write !== 1'b0) begin errors++; $display("FAIL %s rd_start got rd=%b wr=%b want rd=1 wr=0", tag, bmem_read, bmem_write); end
    checks++; if (bmem_address !== exp_addr) begin errors++; $display("FAIL %s rd_addr got %h want %h", tag, bmem_address, exp_addr); end
    pmem_address = $urandom;
    for (int i = 0; i < 16 && beats < 4; i++) begin
      bmem_resp  = pat[i];
      bmem_rdata = pat[i] ? line[beats*64 +: 64] : {$urandom, $urandom};
      @(posedge clk); #1;
      cyc++;
      if (pat[i]) beats++;
      bmem_resp = 1'b0;
      if (beats < 4) begin
        checks++; if ({pmem_resp, bmem_read} !== 2'b01) begin errors++; $display("FAIL %s rd_mid got resp=%b rd=%b want resp=0 rd=1", tag, pmem_resp, bmem_read); end
      end
    end
    checks++; if ({pmem_resp, bmem_read} !== 2'b10) begin errors++; $display("FAIL %s rd_resp got resp=%b rd=%b want resp=1 rd=0", tag, pmem_resp, bmem_read); end
    checks++; if (pmem_rdata !== line) begin errors++; $display("FAIL %s rd_data got %h want %h", tag, pmem_rdata, line); end
    checks++; if (bmem_address !== exp_addr) begin errors++; $display("FAIL %s rd_addr_hold got %h want %h", tag, bmem_address, exp_addr); end
    pmem_read = 1'b0;
    last_line = line;
    @(posedge clk); #1;
    checks++; if (pmem_resp !== 1'b0 || pmem_rdata !== line) begin errors++; $display("FAIL %s rd_after got resp=%b data=%h want resp=0 data=%h", tag, pmem_resp, pmem_rdata, line); end
    $display("read  %s addr=%h line_addr=%h latency=%0d", tag, addr, exp_addr, cyc);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr,
                          input logic [255:0] line, input logic [15:0] pat);
    int beats = 0;
    int cyc = 1;
    logic [31:0] exp_addr = {addr[31:5], 5'b0};
    pmem_write = 1'b1; pmem_address = addr; pmem_wdata = line;
    @(posedge clk); #1;
    checks++; if (bmem_address !== exp_addr) begin errors++; $display("FAIL %s wr_addr got %h want %h", tag, bmem_address, exp_addr); end
    pmem_address = $urandom;
    for (int i = 0; i < 16 && beats < 4; i++) begin
      bmem_resp = pat[i];
      checks++; if ({bmem_write, bmem_read} !== 2'b10 || bmem_wdata !== line[beats*64 +: 64]) begin errors++; $display("FAIL %s wr_beat%0d got wr=%b rd=%b data=%h want wr=1 rd=0 data=%h", tag, beats, bmem_write, bmem_read, bmem_wdata, line[beats*64 +: 64]); end
      @(posedge clk); #1;
      cyc++;
      if (pat[i]) beats++;
      bmem_resp = 1'b0;
      if (beats < 4) begin
        checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL %s wr_mid got resp=%b want 0", tag, pmem_resp); end
      end
    end
    checks++; if ({pmem_resp, bmem_write} !== 2'b10) begin errors++; $display("FAIL %s wr_resp got resp=%b wr=%b want resp=1 wr=0", tag, pmem_resp, bmem_write); end
    checks++; if (pmem_rdata !== last_line) begin errors++; $display("FAIL %s wr_rdata_hold got %h want %h", tag, pmem_rdata, last_line); end
    pmem_write = 1'b0;
    @(posedge clk); #1;
    checks++; if ({pmem_resp, bmem_write, bmem_read} !== 3'b000) begin errors++; $display("FAIL %s wr_after got %b want 000", tag, {pmem_resp, bmem_write, bmem_read}); end
    $display("write %s addr=%h line_addr=%h latency=%0d", tag, addr, exp_addr, cyc);
  endtask

  task automatic test_read_no_stall();
    do_read("rd_nostall", 32'h0000_1234,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'h000F);
  endtask

  task automatic test_write_stall();
    do_write("wr_stall", 32'h0000_5678,
             {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
              64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000}, 16'b1_1101);
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] l = rand_line();
    pmem_read = 1'b1; pmem_address = 32'h0000_2000;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bmem_resp = 1'b1; bmem_rdata = l[i*64 +: 64];
      @(posedge clk); #1;
    end
    bmem_resp = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({bmem_read, pmem_resp} !== 2'b00) begin errors++; $display("FAIL rst_mid ctrl got rd=%b resp=%b want 00", bmem_read, pmem_resp); end
    checks++; if (pmem_rdata !== 256'd0 || bmem_address !== 32'd0) begin errors++; $display("FAIL rst_mid state got data=%h addr=%h want 0", pmem_rdata, bmem_address); end
    pmem_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL rst_hold resp got %b want 0", pmem_resp); end
    rst = 1'b0;
    last_line = '0;
    $display("reset mid-read after 2 beats");
    do_read("after_rst", 32'h0000_0040, rand_line(), 16'h000F);
  endtask

  task automatic test_spurious_resp();
    for (int i = 0; i < 3; i++) begin
      bmem_resp = 1'b1; bmem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++; if ({pmem_resp, bmem_read, bmem_write} !== 3'b000 || pmem_rdata !== last_line) begin errors++; $display("FAIL spurious got ctrl=%b data=%h want 000 data=%h", {pmem_resp, bmem_read, bmem_write}, pmem_rdata, last_line); end
    end
    bmem_resp = 1'b0;
    $display("spurious bmem_resp in IDLE x3");
    do_read("post_spur", 32'h0000_3000, rand_line(), 16'h000F);
  endtask

  task automatic test_back_to_back();
    do_read("b2b_rd", 32'h0001_0000, rand_line(), rand_pat());
    do_write("b2b_wr", 32'h0002_0020, rand_line(), rand_pat());
    do_read("b2b_rd2", 32'h0003_0044, rand_line(), 16'h000F);
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1) do_write("rand", $urandom, rand_line(), rand_pat());
      else                           do_read("rand", $urandom, rand_line(), rand_pat());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_no_stall();
    test_write_stall();
    test_reset_mid_read();
    test_spurious_resp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
